// File: rtl/frog_move_gen_if.sv
// Direction bus between the frog move generator and the grid of light cells.
// master = move generator (drives pulses), slave = grid/board side (drives keys and control).
interface frog_move_gen_if;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;
    logic       enable;
    logic       kill;
    logic       U;
    logic       D;
    logic       L;
    logic       R;
    logic       busy;
    logic [7:0] move_count;

    modport master (
        input  key_up, key_down, key_left, key_right, enable, kill,
        output U, D, L, R, busy, move_count
    );

    modport slave (
        output key_up, key_down, key_left, key_right, enable, kill,
        input  U, D, L, R, busy, move_count
    );
endinterface

// File: rtl/frog_move_gen.sv
// Turns raw direction keys into one-hot, single-cycle U/D/L/R move pulses with cooldown.
// Optional macro FROG_AUTOREPEAT_EN adds auto-repeat while the latched key stays held.
module frog_move_gen #(
    parameter int unsigned COOLDOWN_CYCLES = 4,
    parameter int unsigned REPEAT_CYCLES   = 16
) (
    input  logic               clk,
    input  logic               reset,
    frog_move_gen_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        COOLDOWN,
        WAIT_RELEASE
    } state_t;

    // Bad parameter values are rejected at elaboration rather than silently wrapping.
    if (COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > 255) begin : gen_bad_cooldown
        $error("frog_move_gen: COOLDOWN_CYCLES out of range 1..255");
    end
    if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65535) begin : gen_bad_repeat
        $error("frog_move_gen: REPEAT_CYCLES out of range 1..65535");
    end

    localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_CYCLES - 1);

    // Key vectors are ordered {up, down, left, right}; dir 0..3 follows the same order.
    logic [3:0] rawKeys;
    logic [3:0] syncMeta_q;
    logic [3:0] syncKey_q;
    state_t     state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic [7:0] coolCnt_q, coolCnt_d;
    logic [7:0] moveCnt_q, moveCnt_d;
    logic       abort;
    logic       anyKey;

    assign rawKeys = {bus.key_up, bus.key_down, bus.key_left, bus.key_right};
    assign abort   = bus.kill | ~bus.enable;
    assign anyKey  = |syncKey_q;

`ifdef FROG_AUTOREPEAT_EN
    logic [15:0] repCnt_q, repCnt_d;
    logic        keyHeld;

    assign keyHeld = syncKey_q[2'd3 - dir_q];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            syncMeta_q <= 4'b0000;
            syncKey_q  <= 4'b0000;
            state_q    <= IDLE;
            dir_q      <= 2'd0;
            coolCnt_q  <= 8'd0;
            moveCnt_q  <= 8'd0;
`ifdef FROG_AUTOREPEAT_EN
            repCnt_q   <= 16'd0;
`endif
        end else begin
            syncMeta_q <= rawKeys;
            syncKey_q  <= syncMeta_q;
            state_q    <= state_d;
            dir_q      <= dir_d;
            coolCnt_q  <= coolCnt_d;
            moveCnt_q  <= moveCnt_d;
`ifdef FROG_AUTOREPEAT_EN
            repCnt_q   <= repCnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        coolCnt_d = coolCnt_q;
        moveCnt_d = moveCnt_q;
`ifdef FROG_AUTOREPEAT_EN
        repCnt_d  = repCnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!abort && anyKey) begin
                    if (syncKey_q[3])      dir_d = 2'd0;
                    else if (syncKey_q[2]) dir_d = 2'd1;
                    else if (syncKey_q[1]) dir_d = 2'd2;
                    else                   dir_d = 2'd3;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                if (moveCnt_q != 8'hFF) moveCnt_d = moveCnt_q + 8'd1;
`ifdef FROG_AUTOREPEAT_EN
                repCnt_d = 16'd0;
`endif
                if (abort) begin
                    state_d   = WAIT_RELEASE;
                    coolCnt_d = 8'd0;
                end else begin
                    state_d   = COOLDOWN;
                    coolCnt_d = COOL_LOAD;
                end
            end
            COOLDOWN: begin
                if (abort) begin
                    state_d   = WAIT_RELEASE;
                    coolCnt_d = 8'd0;
                end else if (coolCnt_q == 8'd0) begin
                    state_d = WAIT_RELEASE;
                end else begin
                    coolCnt_d = coolCnt_q - 8'd1;
                end
            end
            WAIT_RELEASE: begin
                // kill/disable pins us here even after release, so a new round starts clean.
                if (!abort && !anyKey) begin
                    state_d = IDLE;
                end
`ifdef FROG_AUTOREPEAT_EN
                if (keyHeld && !abort) begin
                    if (repCnt_q + 16'd1 == 16'(REPEAT_CYCLES)) begin
                        repCnt_d = 16'd0;
                        state_d  = FIRE;
                    end else begin
                        repCnt_d = repCnt_q + 16'd1;
                    end
                end else begin
                    repCnt_d = 16'd0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.U          = (state_q == FIRE) && (dir_q == 2'd0);
    assign bus.D          = (state_q == FIRE) && (dir_q == 2'd1);
    assign bus.L          = (state_q == FIRE) && (dir_q == 2'd2);
    assign bus.R          = (state_q == FIRE) && (dir_q == 2'd3);
    assign bus.busy       = (state_q != IDLE);
    assign bus.move_count = moveCnt_q;

endmodule

// File: tb/tb_frog_move_gen.sv
// Directed self-checking bench for frog_move_gen (COOLDOWN_CYCLES=4, REPEAT_CYCLES=16).
// Inputs change 1 ns after posedge; outputs are read at that same point.
module tb_frog_move_gen;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    frog_move_gen_if bus ();

    frog_move_gen #(
        .COOLDOWN_CYCLES(4),
        .REPEAT_CYCLES  (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cntU = 0, cntD = 0, cntL = 0, cntR = 0, badHot = 0;
    logic [3:0] outs;

    assign outs = {bus.U, bus.D, bus.L, bus.R};

    // Pulse counters: a pulse longer than one cycle is counted more than once.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            cntU += int'(bus.U);
            cntD += int'(bus.D);
            cntL += int'(bus.L);
            cntR += int'(bus.R);
            if ($countones(outs) > 1 || (outs != 4'b0000 && !bus.busy)) badHot++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setKeys(input logic [3:0] k);
        {bus.key_up, bus.key_down, bus.key_left, bus.key_right} = k;
    endtask

    task automatic test_reset;
        reset = 1'b1; bus.enable = 1'b1; bus.kill = 1'b0; setKeys(4'b0000);
        tick(3);
        checks++; if (outs !== 4'b0000) begin errors++; $display("[TB] FAIL reset_outs: got %b expected 0000", outs); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.move_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.move_count); end
        reset = 1'b0;
        tick(1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_single_press;
        int c0 = cntR;
        setKeys(4'b0001);
        tick(2);
        checks++; if (outs !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL press_early: outs %b busy %b expected 0000/0", outs, bus.busy); end
        tick(1);
        checks++; if (outs !== 4'b0001 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL press_pulse: outs %b busy %b expected 0001/1", outs, bus.busy); end
        tick(1);
        checks++; if (outs !== 4'b0000 || bus.move_count !== 8'd1) begin errors++; $display("[TB] FAIL press_after: outs %b count %0d expected 0000/1", outs, bus.move_count); end
        tick(16);
        checks++; if (cntR - c0 != 1 || cntU + cntD + cntL != 0) begin errors++; $display("[TB] FAIL hold_pulses: R %0d others %0d expected 1/0", cntR - c0, cntU + cntD + cntL); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL hold_busy: got %b expected 1", bus.busy); end
        setKeys(4'b0000);
        tick(4);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL release_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_simultaneous;
        int cu = cntU;
        int cl = cntL;
        setKeys(4'b1010);
        tick(10);
        checks++; if (cntU - cu != 1 || cntL - cl != 0) begin errors++; $display("[TB] FAIL simul_priority: U %0d L %0d expected 1/0", cntU - cu, cntL - cl); end
        setKeys(4'b1000);
        tick(6);
        checks++; if (cntL - cl != 0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL partial_release: L %0d busy %b expected 0/1", cntL - cl, bus.busy); end
        setKeys(4'b0000);
        tick(4);
        setKeys(4'b0010);
        tick(3);
        checks++; if (outs !== 4'b0010) begin errors++; $display("[TB] FAIL new_left: got %b expected 0010", outs); end
        tick(6);
        setKeys(4'b0000);
        tick(5);
        checks++; if (cntL - cl != 1 || bus.move_count !== 8'd3) begin errors++; $display("[TB] FAIL left_total: L %0d count %0d expected 1/3", cntL - cl, bus.move_count); end
    endtask

    task automatic test_cooldown;
        int c0 = cntD;
        setKeys(4'b0100);
        tick(1);
        setKeys(4'b0000);
        tick(2);
        checks++; if (outs !== 4'b0100) begin errors++; $display("[TB] FAIL tap_pulse: got %b expected 0100", outs); end
        tick(2);
        setKeys(4'b0100);
        tick(1);
        setKeys(4'b0000);
        tick(3);
        checks++; if (cntD - c0 != 1) begin errors++; $display("[TB] FAIL cooldown_absorb: D %0d expected 1", cntD - c0); end
        setKeys(4'b0100);
        tick(1);
        setKeys(4'b0000);
        tick(2);
        checks++; if (outs !== 4'b0100) begin errors++; $display("[TB] FAIL tap_after6: got %b expected 0100", outs); end
        tick(6);
        checks++; if (cntD - c0 != 2 || bus.move_count !== 8'd5) begin errors++; $display("[TB] FAIL tap_total: D %0d count %0d expected 2/5", cntD - c0, bus.move_count); end
    endtask

    task automatic test_kill;
        int c0 = cntL;
        int cr = cntR;
        int cu = cntU;
        setKeys(4'b0010);
        tick(3);
        checks++; if (outs !== 4'b0010) begin errors++; $display("[TB] FAIL kill_prepulse: got %b expected 0010", outs); end
        tick(1);
        bus.kill = 1'b1;
        tick(1);
        bus.kill = 1'b0;
        tick(10);
        checks++; if (cntL - c0 != 1 || bus.busy !== 1'b1 || bus.move_count !== 8'd6) begin errors++; $display("[TB] FAIL kill_cooldown: L %0d busy %b count %0d expected 1/1/6", cntL - c0, bus.busy, bus.move_count); end
        setKeys(4'b0000);
        tick(4);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL kill_release: busy %b expected 0", bus.busy); end
        setKeys(4'b0010);
        tick(9);
        setKeys(4'b0000);
        tick(5);
        checks++; if (cntL - c0 != 2 || bus.move_count !== 8'd7) begin errors++; $display("[TB] FAIL kill_repress: L %0d count %0d expected 2/7", cntL - c0, bus.move_count); end
        // kill arriving during FIRE must not cut the pulse short
        setKeys(4'b0001);
        tick(3);
        bus.kill = 1'b1;
        #1;
        checks++; if (outs !== 4'b0001) begin errors++; $display("[TB] FAIL kill_in_fire: got %b expected 0001", outs); end
        tick(1);
        checks++; if (outs !== 4'b0000 || bus.busy !== 1'b1 || bus.move_count !== 8'd8) begin errors++; $display("[TB] FAIL kill_after_fire: outs %b busy %b count %0d expected 0000/1/8", outs, bus.busy, bus.move_count); end
        setKeys(4'b0000);
        tick(3);
        bus.kill = 1'b0;
        tick(3);
        checks++; if (bus.busy !== 1'b0 || cntR - cr != 1) begin errors++; $display("[TB] FAIL kill_fire_done: busy %b R %0d expected 0/1", bus.busy, cntR - cr); end
        bus.kill = 1'b1;
        setKeys(4'b1000);
        tick(6);
        checks++; if (bus.busy !== 1'b0 || cntU - cu != 0) begin errors++; $display("[TB] FAIL kill_idle: busy %b U %0d expected 0/0", bus.busy, cntU - cu); end
        setKeys(4'b0000);
        tick(3);
        bus.kill = 1'b0;
        tick(1);
    endtask

    task automatic test_enable;
        int cu = cntU;
        bus.enable = 1'b0;
        setKeys(4'b1000);
        tick(6);
        checks++; if (bus.busy !== 1'b0 || cntU - cu != 0 || bus.move_count !== 8'd8) begin errors++; $display("[TB] FAIL disabled: busy %b U %0d count %0d expected 0/0/8", bus.busy, cntU - cu, bus.move_count); end
        setKeys(4'b0000);
        tick(3);
        bus.enable = 1'b1;
        tick(1);
    endtask

    task automatic test_reset_mid;
        setKeys(4'b1000);
        tick(3);
        checks++; if (outs !== 4'b1000) begin errors++; $display("[TB] FAIL mid_prepulse: got %b expected 1000", outs); end
        reset = 1'b1;
        tick(1);
        checks++; if (outs !== 4'b0000 || bus.busy !== 1'b0 || bus.move_count !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset: outs %b busy %b count %0d expected 0000/0/0", outs, bus.busy, bus.move_count); end
        reset = 1'b0;
        setKeys(4'b0000);
        tick(4);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 260; i++) begin
            setKeys(4'b0001);
            tick(3);
            setKeys(4'b0000);
            tick(9);
            if (i == 253) begin
                checks++; if (bus.move_count !== 8'd254) begin errors++; $display("[TB] FAIL count_254: got %0d expected 254", bus.move_count); end
            end
        end
        checks++; if (bus.move_count !== 8'd255) begin errors++; $display("[TB] FAIL count_saturate: got %0d expected 255", bus.move_count); end
    endtask

    task automatic test_autorepeat;
        int cu = cntU;
        int expected;
`ifdef FROG_AUTOREPEAT_EN
        expected = 3;
`else
        expected = 1;
`endif
        setKeys(4'b1000);
        tick(60);
        setKeys(4'b0000);
        tick(5);
        checks++; if (cntU - cu != expected) begin errors++; $display("[TB] FAIL hold_repeat: U %0d expected %0d", cntU - cu, expected); end
    endtask

    task automatic test_onehot;
        checks++; if (badHot != 0) begin errors++; $display("[TB] FAIL onehot: violations %0d expected 0", badHot); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_cooldown();
        test_kill();
        test_enable();
        test_reset_mid();
        test_saturation();
        test_autorepeat();
        test_onehot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
